uart_rx_cmd_ctrl: RTL

- Command sequencer behind the UART receiver.
- Consumes the receiver's byte stream (P_DATA/data_valid plus parity/stop error flags) and assembles multi-byte command frames.
- Issues single-cycle register-file write/read strobes and ALU launch strobes.
- Aborts malformed or stalled frames; sits between UART_RX_TOP and the register file / ALU.

---
 rtl/uart_rx_cmd_ctrl_if.sv | 57 +++++
 rtl/uart_rx_cmd_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cmd_ctrl_if.sv
// Handshake/bus bundle between the UART receiver, command sequencer and
// register file / ALU.
//   rx side : rx_p_data, rx_data_valid, parity_error, stop_error
//   rf side : rf_wr_en, rf_rd_en, rf_addr, rf_wr_data
//   alu side: alu_en, alu_fun
//   status  : busy, frame_err
// master drives the receive byte stream; slave is the sequencer.
interface uart_rx_cmd_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic [DATA_WIDTH-1:0] rx_p_data;
    logic                  rx_data_valid;
    logic                  parity_error;
    logic                  stop_error;

    logic                  rf_wr_en;
    logic                  rf_rd_en;
    logic [ADDR_WIDTH-1:0] rf_addr;
    logic [DATA_WIDTH-1:0] rf_wr_data;

    logic                  alu_en;
    logic [3:0]            alu_fun;

    logic                  busy;
    logic                  frame_err;

    modport master (
        output rx_p_data,
        output rx_data_valid,
        output parity_error,
        output stop_error,
        input  rf_wr_en,
        input  rf_rd_en,
        input  rf_addr,
        input  rf_wr_data,
        input  alu_en,
        input  alu_fun,
        input  busy,
        input  frame_err
    );

    modport slave (
        input  rx_p_data,
        input  rx_data_valid,
        input  parity_error,
        input  stop_error,
        output rf_wr_en,
        output rf_rd_en,
        output rf_addr,
        output rf_wr_data,
        output alu_en,
        output alu_fun,
        output busy,
        output frame_err
    );
endinterface

// File: rtl/uart_rx_cmd_ctrl.sv
// Command sequencer behind the UART receiver: assembles multi-byte command
// frames and issues single-cycle register-file and ALU strobes.
// Ports: clk, rst (sync, active-high), bus (uart_rx_cmd_ctrl_if.slave).
// Frames: AA addr data -> write | BB addr -> read |
//         CC opa opb fun -> two operand writes + ALU | DD fun -> ALU.
module uart_rx_cmd_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int TIMEOUT    = 50000,
    parameter int OPA_ADDR   = 0,
    parameter int OPB_ADDR   = 1
) (
    input  logic                clk,
    input  logic                rst,
    uart_rx_cmd_ctrl_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_ADDR,
        S_WR_DATA,
        S_RD_ADDR,
        S_ALU_OPA,
        S_ALU_OPB,
        S_ALU_FUN
    } state_t;

    localparam logic [15:0] LP_TO_LAST = 16'(TIMEOUT - 1);

    localparam logic [DATA_WIDTH-1:0] LP_CMD_WR  = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] LP_CMD_RD  = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] LP_CMD_ALU = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] LP_CMD_FUN = DATA_WIDTH'(8'hDD);

    localparam logic [ADDR_WIDTH-1:0] LP_OPA = ADDR_WIDTH'(OPA_ADDR);
    localparam logic [ADDR_WIDTH-1:0] LP_OPB = ADDR_WIDTH'(OPB_ADDR);

    state_t                r_state;
    logic [15:0]           r_to_cnt;
    logic [ADDR_WIDTH-1:0] r_wr_addr;

    logic                  r_wr_en;
    logic                  r_rd_en;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wr_data;
    logic                  r_alu_en;
    logic [3:0]            r_alu_fun;
    logic                  r_busy;
    logic                  r_frame_err;

    logic                  w_line_err;
    logic                  w_accept;
    logic [DATA_WIDTH-1:0] w_byte;

    // A line error poisons the byte even when rx_data_valid is high.
    assign w_line_err = bus.parity_error | bus.stop_error;
    assign w_accept   = bus.rx_data_valid & ~w_line_err;
    assign w_byte     = bus.rx_p_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_to_cnt    <= '0;
            r_wr_addr   <= '0;
            r_wr_en     <= 1'b0;
            r_rd_en     <= 1'b0;
            r_addr      <= '0;
            r_wr_data   <= '0;
            r_alu_en    <= 1'b0;
            r_alu_fun   <= '0;
            r_busy      <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            // Strobes are single-cycle; data fields hold their last value.
            r_wr_en     <= 1'b0;
            r_rd_en     <= 1'b0;
            r_alu_en    <= 1'b0;
            r_frame_err <= 1'b0;

            if (w_line_err) begin
                r_state     <= S_IDLE;
                r_busy      <= 1'b0;
                r_to_cnt    <= '0;
                r_frame_err <= 1'b1;
            end else if (w_accept) begin
                // An accepted byte beats a timeout landing on the same edge.
                r_to_cnt <= '0;
                unique case (r_state)
                    S_IDLE: begin
                        case (w_byte)
                            LP_CMD_WR: begin
                                r_state <= S_WR_ADDR;
                                r_busy  <= 1'b1;
                            end
                            LP_CMD_RD: begin
                                r_state <= S_RD_ADDR;
                                r_busy  <= 1'b1;
                            end
                            LP_CMD_ALU: begin
                                r_state <= S_ALU_OPA;
                                r_busy  <= 1'b1;
                            end
                            LP_CMD_FUN: begin
                                r_state <= S_ALU_FUN;
                                r_busy  <= 1'b1;
                            end
                            default: begin
                                r_frame_err <= 1'b1;
                            end
                        endcase
                    end
                    S_WR_ADDR: begin
                        r_wr_addr <= w_byte[ADDR_WIDTH-1:0];
                        r_state   <= S_WR_DATA;
                    end
                    S_WR_DATA: begin
                        r_wr_en   <= 1'b1;
                        r_addr    <= r_wr_addr;
                        r_wr_data <= w_byte;
                        r_state   <= S_IDLE;
                        r_busy    <= 1'b0;
                    end
                    S_RD_ADDR: begin
                        r_rd_en <= 1'b1;
                        r_addr  <= w_byte[ADDR_WIDTH-1:0];
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                    S_ALU_OPA: begin
                        r_wr_en   <= 1'b1;
                        r_addr    <= LP_OPA;
                        r_wr_data <= w_byte;
                        r_state   <= S_ALU_OPB;
                    end
                    S_ALU_OPB: begin
                        r_wr_en   <= 1'b1;
                        r_addr    <= LP_OPB;
                        r_wr_data <= w_byte;
                        r_state   <= S_ALU_FUN;
                    end
                    S_ALU_FUN: begin
                        r_alu_en  <= 1'b1;
                        r_alu_fun <= w_byte[3:0];
                        r_state   <= S_IDLE;
                        r_busy    <= 1'b0;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end else if (r_state == S_IDLE) begin
                r_to_cnt <= '0;
            end else if (r_to_cnt == LP_TO_LAST) begin
                // Frame stalled: the sender went quiet mid-frame.
                r_state     <= S_IDLE;
                r_busy      <= 1'b0;
                r_to_cnt    <= '0;
                r_frame_err <= 1'b1;
            end else begin
                r_to_cnt <= r_to_cnt + 16'd1;
            end
        end
    end

    assign bus.rf_wr_en   = r_wr_en;
    assign bus.rf_rd_en   = r_rd_en;
    assign bus.rf_addr    = r_addr;
    assign bus.rf_wr_data = r_wr_data;
    assign bus.alu_en     = r_alu_en;
    assign bus.alu_fun    = r_alu_fun;
    assign bus.busy       = r_busy;
    assign bus.frame_err  = r_frame_err;

endmodule
